// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both ends of the link: frame length,
// clock mode, the responder FSM encoding and a counter-width helper.
package spi_pkg;

    // Fixed frame length exchanged by master and slave (5 bytes).
    localparam int SPI_FRAME_BITS = 40;

    // Clock mode shared with the master: sck idles low and data is
    // sampled on the leading edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Responder FSM encoding.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_t;

    // Bit counter width. The counter must hold 0..size+1 so that an
    // over-length frame can saturate one above the legal length.
    function automatic int spi_cnt_width(input int size);
        return $clog2(size + 2);
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizer for one external SPI pin into the clk domain. Produces the
// synced level plus registered 1-clk rise/fall strobes aligned with it.
// Pin-to-strobe latency is SYNC_LEN+1 clk.
module spi_slave_sync #(
    parameter int   SYNC_LEN  = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_LEN-1:0] sync_reg;
    logic                prev_reg;
    logic                rise_reg;
    logic                fall_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous pin.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= RESET_VAL;
                    else        sync_reg[gi] <= din;
                end
            end else begin : g_rest
                // Further stages resolve metastability.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= RESET_VAL;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Edge detect on the last two synced samples; the delayed sample is the
    // exported level so that level and strobes refer to the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= RESET_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[SYNC_LEN-1];
            rise_reg <= sync_reg[SYNC_LEN-1] & ~prev_reg;
            fall_reg <= ~sync_reg[SYNC_LEN-1] & prev_reg;
        end
    end

    assign level = prev_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI responder (CPOL=0, CPHA=0). All pins are oversampled in clk; nothing
// is clocked by sck. Each frame shifts SIZE bits MSB first: the received
// word is published on rx_bytes, and tx_bytes (captured at cs fall) is
// returned on miso.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SIZE     = SPI_FRAME_BITS,
    parameter int SYNC_LEN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] tx_bytes,
    output logic            tx_latched,
    output logic [SIZE-1:0] rx_bytes,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            busy,
    input  logic            cs,
    input  logic            sck,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe
);

    localparam int              CNT_W    = spi_cnt_width(SIZE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SIZE + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    // cs idles high so the first real cs fall is not lost or faked.
    spi_slave_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_slave_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(SPI_CPOL)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_slave_sync #(.SYNC_LEN(SYNC_LEN), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only the synced mosi level and the sck strobes are needed.
    logic unused_sync_bits;
    assign unused_sync_bits = mosi_rise ^ mosi_fall ^ sck_s;

    // Leading sck edge samples mosi, trailing edge advances miso.
    logic sample_edge, shift_edge;
    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sck_fall : sck_rise;
    assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sck_rise : sck_fall;

    spi_state_t       state_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [SIZE-1:0]  tx_sr_reg;
    logic [SIZE-1:0]  rx_sr_reg;
    logic [SIZE-1:0]  rx_bytes_reg;
    logic             rx_valid_reg;
    logic             frame_err_reg;
    logic             tx_latched_reg;

    // Frame FSM: load tx word on cs fall, shift on sck edges, and judge
    // the frame length on cs rise. cs rise outranks same-cycle sck edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= '0;
            tx_sr_reg      <= '0;
            rx_sr_reg      <= '0;
            rx_bytes_reg   <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            tx_latched_reg <= 1'b0;
        end else begin
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            tx_latched_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cs_fall) begin
                        tx_sr_reg      <= tx_bytes;
                        tx_latched_reg <= 1'b1;
                        bit_cnt_reg    <= '0;
                        state_reg      <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise) begin
                        state_reg <= S_IDLE;
                        if (bit_cnt_reg == CNT_FULL) begin
                            rx_bytes_reg <= rx_sr_reg;
                            rx_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else if (!cs_fall) begin
                        if (sample_edge) begin
                            rx_sr_reg <= {rx_sr_reg[SIZE-2:0], mosi_s};
                            if (bit_cnt_reg != CNT_MAX)
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                        if (shift_edge) begin
                            tx_sr_reg <= {tx_sr_reg[SIZE-2:0], 1'b0};
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign tx_latched = tx_latched_reg;
    assign rx_bytes   = rx_bytes_reg;
    assign rx_valid   = rx_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg == S_ACTIVE);
    assign miso       = (state_reg == S_ACTIVE) ? tx_sr_reg[SIZE-1] : 1'b0;
    assign miso_oe    = ~cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural 1 MHz SPI master drives
// frames and checks the received/returned words, strobes and idle behaviour.
module tb_spi_slave;

    localparam int SIZE     = 40;
    localparam int SYNC_LEN = 2;
    localparam int HALF     = 25;   // clk periods per sck phase (1 MHz)

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [SIZE-1:0] tx_bytes = '0;
    logic            tx_latched;
    logic [SIZE-1:0] rx_bytes;
    logic            rx_valid;
    logic            frame_err;
    logic            busy;
    logic            cs = 1'b1;
    logic            sck = 1'b0;
    logic            mosi = 1'b0;
    logic            miso;
    logic            miso_oe;

    spi_slave #(.SIZE(SIZE), .SYNC_LEN(SYNC_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_bytes   (tx_bytes),
        .tx_latched (tx_latched),
        .rx_bytes   (rx_bytes),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .cs         (cs),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse monitors: monotonic counters plus a log of published words.
    int              rv_cnt = 0;
    int              fe_cnt = 0;
    int              tl_cnt = 0;
    logic [SIZE-1:0] rx_log [0:15];

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rv_cnt < 16) rx_log[rv_cnt] = rx_bytes;
            rv_cnt = rv_cnt + 1;
        end
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (tx_latched) tl_cnt = tl_cnt + 1;
    end

    // Results of the most recent master frame.
    logic            miso_bits [0:63];
    logic [SIZE-1:0] mi_word;
    logic            miso_early;

    // Behavioural CPOL=0/CPHA=0 master. Called right after a negedge.
    // Drives cs low now, samples miso at each sck rise, changes mosi after
    // each fall; optionally swaps tx_bytes after bit 20 and leaves cs low.
    task automatic spi_frame(input logic [SIZE-1:0] mo, input int nbits,
                             input bit raise_cs, input bit chg,
                             input logic [SIZE-1:0] tx_new);
        cs = 1'b0;
        mosi = mo[SIZE-1];
        mi_word = '0;
        miso_early = 1'b0;
        for (int c = 1; c <= HALF; c++) begin
            @(negedge clk);
            if (c == SYNC_LEN + 2) miso_early = miso;
        end
        for (int b = 0; b < nbits; b++) begin
            sck = 1'b1;
            miso_bits[b] = miso;
            if (b < SIZE) mi_word = {mi_word[SIZE-2:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
            if (chg && b == 19) tx_bytes = tx_new;
            repeat (HALF) @(negedge clk);
            if (b + 1 < SIZE) mosi = mo[SIZE-2-b];
            else              mosi = 1'b0;
        end
        if (raise_cs) cs = 1'b1;
        $display("frame: bits=%0d mosi_word=%h miso_word=%h cs_raised=%0d",
                 nbits, mo, mi_word, raise_cs);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_bytes !== '0) begin bad++; $display("FAIL reset_rx_bytes got=%h want=0", rx_bytes); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (tx_latched !== 1'b0) begin bad++; $display("FAIL reset_tx_latched got=%b want=0", tx_latched); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got=%b want=0", miso_oe); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_loopback();
        int rv0 = rv_cnt;
        int fe0 = fe_cnt;
        tx_bytes = 40'h12_34_56_78_9A;
        spi_frame(40'hA5_5A_0F_F0_3C, 40, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        total++; if (rx_bytes !== 40'hA5_5A_0F_F0_3C) begin bad++; $display("FAIL loop_rx_bytes got=%h want=a55a0ff03c", rx_bytes); end
        total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL loop_rx_valid_count got=%0d want=1", rv_cnt - rv0); end
        total++; if (mi_word !== 40'h12_34_56_78_9A) begin bad++; $display("FAIL loop_master_in got=%h want=123456789a", mi_word); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL loop_frame_err_count got=%0d want=0", fe_cnt - fe0); end
    endtask

    task automatic test_miso_bits();
        int   tl0 = tl_cnt;
        logic mid_any = 1'b0;
        tx_bytes = 40'h80_00_00_00_01;
        spi_frame(40'hC3_00_FF_00_11, 40, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        for (int b = 1; b <= 38; b++) mid_any = mid_any | miso_bits[b];
        total++; if (miso_early !== 1'b1) begin bad++; $display("FAIL miso_early got=%b want=1", miso_early); end
        total++; if (miso_bits[0] !== 1'b1) begin bad++; $display("FAIL miso_bit1 got=%b want=1", miso_bits[0]); end
        total++; if (mid_any !== 1'b0) begin bad++; $display("FAIL miso_bits_2_39 got=%b want=0", mid_any); end
        total++; if (miso_bits[39] !== 1'b1) begin bad++; $display("FAIL miso_bit40 got=%b want=1", miso_bits[39]); end
        total++; if (tl_cnt - tl0 !== 1) begin bad++; $display("FAIL tx_latched_count got=%0d want=1", tl_cnt - tl0); end
        total++; if (rx_bytes !== 40'hC3_00_FF_00_11) begin bad++; $display("FAIL miso_rx_bytes got=%h want=c300ff0011", rx_bytes); end
    endtask

    task automatic test_short_long();
        int rv0 = rv_cnt;
        int fe0 = fe_cnt;
        spi_frame(40'h11_22_33_44_55, 39, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL short_frame_err got=%0d want=1", fe_cnt - fe0); end
        total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL short_rx_valid got=%0d want=0", rv_cnt - rv0); end
        total++; if (rx_bytes !== 40'hC3_00_FF_00_11) begin bad++; $display("FAIL short_rx_kept got=%h want=c300ff0011", rx_bytes); end
        tx_bytes = 40'hFF_FF_FF_FF_FF;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        spi_frame(40'h66_77_88_99_AA, 41, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL long_frame_err got=%0d want=1", fe_cnt - fe0); end
        total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL long_rx_valid got=%0d want=0", rv_cnt - rv0); end
        total++; if (miso_bits[39] !== 1'b1) begin bad++; $display("FAIL long_miso_bit40 got=%b want=1", miso_bits[39]); end
        total++; if (miso_bits[40] !== 1'b0) begin bad++; $display("FAIL long_miso_bit41 got=%b want=0", miso_bits[40]); end
    endtask

    task automatic test_back_to_back();
        int              rv0 = rv_cnt;
        int              fe0 = fe_cnt;
        logic [SIZE-1:0] mi1;
        tx_bytes = 40'hF0_0F_00_CC_33;
        spi_frame(40'h00_00_00_00_01, 40, 1'b1, 1'b1, 40'h0F_F0_11_22_44);
        mi1 = mi_word;
        repeat (4) @(negedge clk);
        spi_frame(40'h00_00_00_00_02, 40, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        total++; if (rv_cnt - rv0 !== 2) begin bad++; $display("FAIL b2b_rx_valid_count got=%0d want=2", rv_cnt - rv0); end
        total++; if (rx_log[rv0] !== 40'h1) begin bad++; $display("FAIL b2b_rx_first got=%h want=1", rx_log[rv0]); end
        total++; if (rx_log[rv0+1] !== 40'h2) begin bad++; $display("FAIL b2b_rx_second got=%h want=2", rx_log[rv0+1]); end
        total++; if (mi1 !== 40'hF0_0F_00_CC_33) begin bad++; $display("FAIL b2b_miso_first got=%h want=f00f00cc33", mi1); end
        total++; if (mi_word !== 40'h0F_F0_11_22_44) begin bad++; $display("FAIL b2b_miso_second got=%h want=0ff0112244", mi_word); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_frame_err got=%0d want=0", fe_cnt - fe0); end
    endtask

    task automatic test_reset_mid_frame();
        int rv0 = rv_cnt;
        int fe0 = fe_cnt;
        tx_bytes = 40'h55_55_55_55_55;
        spi_frame(40'hFF_00_FF_00_FF, 20, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rx_bytes !== '0) begin bad++; $display("FAIL midrst_rx_bytes got=%h want=0", rx_bytes); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b want=0", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL midrst_miso_oe got=%b want=0", miso_oe); end
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL midrst_rx_valid got=%0d want=0", rv_cnt - rv0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL midrst_frame_err got=%0d want=0", fe_cnt - fe0); end
        tx_bytes = 40'h3C_3C_A5_A5_0F;
        spi_frame(40'hDE_AD_BE_EF_01, 40, 1'b1, 1'b0, '0);
        repeat (10) @(negedge clk);
        total++; if (rx_bytes !== 40'hDE_AD_BE_EF_01) begin bad++; $display("FAIL postrst_rx_bytes got=%h want=deadbeef01", rx_bytes); end
        total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL postrst_rx_valid got=%0d want=1", rv_cnt - rv0); end
        total++; if (mi_word !== 40'h3C_3C_A5_A5_0F) begin bad++; $display("FAIL postrst_master_in got=%h want=3c3ca5a50f", mi_word); end
    endtask

    task automatic test_idle_sck();
        int   rv0 = rv_cnt;
        int   fe0 = fe_cnt;
        logic busy_seen = 1'b0;
        logic oe_seen = 1'b0;
        cs = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sck = 1'b1;
            mosi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            busy_seen = busy_seen | busy;
            oe_seen = oe_seen | miso_oe;
            sck = 1'b0;
            repeat (4) @(negedge clk);
            busy_seen = busy_seen | busy;
            oe_seen = oe_seen | miso_oe;
        end
        repeat (10) @(negedge clk);
        $display("idle: 100 sck pulses with cs high");
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy_seen); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL idle_miso_oe got=%b want=0", oe_seen); end
        total++; if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL idle_rx_valid got=%0d want=0", rv_cnt - rv0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL idle_frame_err got=%0d want=0", fe_cnt - fe0); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_bits();
        test_short_long();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_sck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
